// File: rtl/elastic_fifo.sv
// Parametrised-depth valid/ready FIFO with optional fall-through bypass and level/almost-full status.
// Optional synchronous flush port is enabled by defining ELASTIC_FIFO_FLUSH_EN.
module elastic_fifo #(
  parameter int  DATA_WIDTH   = 1,
  parameter type TYPE         = logic [DATA_WIDTH-1:0],
  parameter int  DEPTH        = 2,
  parameter int  FALL_THROUGH = 0,
  // A threshold below 1 would pin almost_full high, so a single-entry FIFO defaults to 1.
  parameter int  AF_THRESH    = (DEPTH > 1) ? DEPTH - 1 : 1,
  localparam int LW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          w_valid,
  output logic          w_ready,
  input  TYPE           w_data,
  output logic          r_valid,
  input  logic          r_ready,
  output TYPE           r_data,
  output logic [LW-1:0] level,
`ifdef ELASTIC_FIFO_FLUSH_EN
  input  logic          flush,
`endif
  output logic          almost_full
);

  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
  localparam logic [LW-1:0]   FULL_CNT = LW'(DEPTH);
  localparam logic [LW-1:0]   AF_CNT   = LW'(AF_THRESH);

  TYPE           mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [LW-1:0] count_nxt;

  logic flush_act;
  logic empty;
  logic full;
  logic bypass_mode;
  logic push;
  logic pop;
  logic bypass;
  logic do_write;
  logic do_read;

`ifdef ELASTIC_FIFO_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign bypass_mode = (FALL_THROUGH != 0) && empty;

  // w_ready depends only on registered count (and flush), never on r_ready.
  assign w_ready = !full && !flush_act;
  assign r_valid = !flush_act && (bypass_mode ? w_valid : !empty);
  assign r_data  = bypass_mode ? w_data : mem[rd_ptr];
  assign level   = count;

  assign push     = w_valid && w_ready;
  assign pop      = r_valid && r_ready;
  assign bypass   = bypass_mode && push && pop;
  assign do_write = push && !bypass;
  assign do_read  = pop && !bypass;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_nxt = count;
    if (flush_act) begin
      count_nxt = '0;
    end else begin
      unique case ({do_write, do_read})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (flush_act) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_write) wr_ptr <= ptr_inc(wr_ptr);
        if (do_read)  rd_ptr <= ptr_inc(rd_ptr);
      end
      count       <= count_nxt;
      almost_full <= (count_nxt >= AF_CNT);
    end
  end

  // NOTE: storage is deliberately not reset; r_valid qualifies r_data, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= w_data;
  end

endmodule

// File: tb/tb_elastic_fifo.sv
// Randomised + directed bench for elastic_fifo: several configurations run side by side,
// each checked against a queue-based reference model by a negedge monitor.
module tb_elastic_fifo;

  localparam int NI = 6;
  localparam int DEP [NI] = '{4, 3, 2, 5, 1, 3};
  localparam int FT  [NI] = '{0, 0, 1, 0, 0, 1};
  localparam int AF  [NI] = '{3, 2, 1, 4, 1, 1};

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       w_valid [NI];
  logic       w_ready [NI];
  logic [7:0] w_data  [NI];
  logic       r_valid [NI];
  logic       r_ready [NI];
  logic [7:0] r_data  [NI];
  logic [7:0] level   [NI];
  logic       af      [NI];
`ifdef ELASTIC_FIFO_FLUSH_EN
  logic       flush   [NI];
`endif

  int checks = 0;
  int failures = 0;
  int pops [NI];
  logic [7:0] mq [NI][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LWG = $clog2(DEP[g] + 1);
    logic [LWG-1:0] lvl;
    elastic_fifo #(
      .DATA_WIDTH  (8),
      .DEPTH       (DEP[g]),
      .FALL_THROUGH(FT[g]),
      .AF_THRESH   (AF[g])
    ) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .w_valid    (w_valid[g]),
      .w_ready    (w_ready[g]),
      .w_data     (w_data[g]),
      .r_valid    (r_valid[g]),
      .r_ready    (r_ready[g]),
      .r_data     (r_data[g]),
      .level      (lvl),
`ifdef ELASTIC_FIFO_FLUSH_EN
      .flush      (flush[g]),
`endif
      .almost_full(af[g])
    );
    assign level[g] = 8'(lvl);
  end

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", name, g, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue per instance; expected outputs follow from its occupancy.
  always @(negedge clk) begin
    int   sz;
    logic fl, ew, ev, push_m, pop_m;
    logic [7:0] ed;
    for (int g = 0; g < NI; g++) begin
`ifdef ELASTIC_FIFO_FLUSH_EN
      fl = flush[g];
`else
      fl = 1'b0;
`endif
      if (!rstn) mq[g].delete();
      sz = mq[g].size();
      ew = (sz != DEP[g]) && !fl;
      ev = !fl && ((sz != 0) || ((FT[g] != 0) && w_valid[g]));
      check("w_ready", g, 32'(w_ready[g]), 32'(ew));
      check("r_valid", g, 32'(r_valid[g]), 32'(ev));
      check("level", g, 32'(level[g]), 32'(sz));
      check("almost_full", g, 32'(af[g]), 32'(sz >= AF[g]));
      push_m = rstn && w_valid[g] && ew;
      pop_m  = rstn && ev && r_ready[g];
      if (push_m) mq[g].push_back(w_data[g]);
      if (pop_m) begin
        ed = mq[g].pop_front();
        check("r_data", g, 32'(r_data[g]), 32'(ed));
        pops[g]++;
      end
      if (rstn && fl) mq[g].delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int g = 0; g < NI; g++) begin
      w_valid[g] = 1'b0;
      r_ready[g] = 1'b0;
      w_data[g]  = 8'h00;
`ifdef ELASTIC_FIFO_FLUSH_EN
      flush[g]   = 1'b0;
`endif
    end
  endtask

  initial begin
    int p0;
    int wp, rp;
    for (int g = 0; g < NI; g++) pops[g] = 0;
    idle_all();
    repeat (3) step();
    rstn = 1'b1;
    step();

    // Fill DEPTH=4 with A1..A4, watching level and almost_full per beat.
    for (int i = 0; i <= 4; i++) begin
      step();
      check("t1_level", 0, 32'(level[0]), i);
      check("t1_af", 0, 32'(af[0]), 32'(i >= 3));
      if (i < 4) begin
        w_valid[0] = 1'b1;
        w_data[0]  = 8'hA1 + 8'(i);
      end else begin
        w_valid[0] = 1'b0;
        check("t1_w_ready_full", 0, 32'(w_ready[0]), 0);
      end
    end
    // Full with simultaneous push/pop: pop happens, push refused.
    w_valid[0] = 1'b1;
    w_data[0]  = 8'hA5;
    r_ready[0] = 1'b1;
    step();
    w_valid[0] = 1'b0;
    check("t4_level", 0, 32'(level[0]), 3);
    check("t4_w_ready", 0, 32'(w_ready[0]), 1);
    repeat (4) step();
    idle_all();

    // DEPTH=3 streaming: 20 cycles, 1-cycle latency then 1 beat/cycle.
    p0 = pops[1];
    for (int i = 0; i < 20; i++) begin
      step();
      w_valid[1] = 1'b1;
      w_data[1]  = 8'h10 + 8'(i);
      r_ready[1] = 1'b1;
    end
    step();
    w_valid[1] = 1'b0;
    check("t2_pops", 1, pops[1] - p0, 19);
    check("t2_level", 1, 32'(level[1]), 1);
    step();
    idle_all();

    // DEPTH=2 fall-through bypass when empty.
    step();
    w_valid[2] = 1'b1;
    w_data[2]  = 8'h5C;
    r_ready[2] = 1'b1;
    #1;
    check("t3_r_valid", 2, 32'(r_valid[2]), 1);
    check("t3_r_data", 2, 32'(r_data[2]), 32'h5C);
    check("t3_level", 2, 32'(level[2]), 0);
    step();
    idle_all();
    check("t3_level_after", 2, 32'(level[2]), 0);

    // DEPTH=5: two entries held, asynchronous reset mid-stream.
    step();
    w_valid[3] = 1'b1;
    w_data[3]  = 8'h31;
    step();
    w_data[3]  = 8'h32;
    step();
    check("t5_level_before", 3, 32'(level[3]), 2);
    w_data[3] = 8'h33;
    rstn = 1'b0;
    #1;
    check("t5_level_rst", 3, 32'(level[3]), 0);
    check("t5_r_valid_rst", 3, 32'(r_valid[3]), 0);
    check("t5_w_ready_rst", 3, 32'(w_ready[3]), 1);
    step();
    rstn = 1'b1;
    w_data[3] = 8'h77;
    step();
    w_valid[3] = 1'b0;
    r_ready[3] = 1'b1;
    #1;
    check("t5_r_valid", 3, 32'(r_valid[3]), 1);
    check("t5_first_beat", 3, 32'(r_data[3]), 32'h77);
    step();
    idle_all();

`ifdef ELASTIC_FIFO_FLUSH_EN
    // Flush with 3 entries and a same-cycle write.
    for (int i = 0; i < 3; i++) begin
      step();
      w_valid[0] = 1'b1;
      w_data[0]  = 8'hC0 + 8'(i);
    end
    step();
    flush[0] = 1'b1;
    w_data[0] = 8'hCF;
    step();
    idle_all();
    check("t6_level", 0, 32'(level[0]), 0);
    check("t6_r_valid", 0, 32'(r_valid[0]), 0);
`endif

    // Randomised traffic on all instances with varying densities.
    for (int blk = 0; blk < 12; blk++) begin
      wp = $urandom_range(20, 95);
      rp = $urandom_range(20, 95);
      for (int c = 0; c < 250; c++) begin
        step();
        for (int g = 0; g < NI; g++) begin
          w_valid[g] = ($urandom_range(0, 99) < wp);
          w_data[g]  = 8'($urandom);
          r_ready[g] = ($urandom_range(0, 99) < rp);
`ifdef ELASTIC_FIFO_FLUSH_EN
          flush[g]   = ($urandom_range(0, 99) < 2);
`endif
        end
      end
    end

    // Drain everything; each accepted beat must have come out.
    idle_all();
    for (int g = 0; g < NI; g++) r_ready[g] = 1'b1;
    repeat (12) step();
    for (int g = 0; g < NI; g++) begin
      check("drain_level", g, 32'(level[g]), 0);
      check("drain_r_valid", g, 32'(r_valid[g]), 0);
    end
    idle_all();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
